// File: rtl/ex_alu_mult_unit.sv
// EX-stage execute unit: single-cycle ALU with registered result/branch flag,
// plus a multi-cycle signed shift-add multiplier writing HI/LO.
// Optional build macro MULT_EARLY_EXIT_EN: finish a multiply as soon as the
// remaining multiplier bits are all zero (results identical, fewer cycles).
module ex_alu_mult_unit #(
    parameter int WIDTH     = 32,
    parameter int MUL_CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ValidIn,
    input  logic [4:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Branch,
    output logic             ValidOut,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Stall
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MULT = 5'b00011;
    localparam logic [4:0] OP_SB   = 5'b00110;
    localparam logic [4:0] OP_LH   = 5'b00111;
    localparam logic [4:0] OP_LB   = 5'b01000;
    localparam logic [4:0] OP_SH   = 5'b01001;
    localparam logic [4:0] OP_BGEZ = 5'b01010;
    localparam logic [4:0] OP_BEQ  = 5'b01011;
    localparam logic [4:0] OP_BNE  = 5'b01100;
    localparam logic [4:0] OP_BGTZ = 5'b01101;
    localparam logic [4:0] OP_BLEZ = 5'b01110;
    localparam logic [4:0] OP_BLTZ = 5'b01111;
    localparam logic [4:0] OP_JR   = 5'b10001;
    localparam logic [4:0] OP_AND  = 5'b10011;
    localparam logic [4:0] OP_ANDI = 5'b10100;
    localparam logic [4:0] OP_OR   = 5'b10101;
    localparam logic [4:0] OP_NOR  = 5'b10110;
    localparam logic [4:0] OP_XOR  = 5'b10111;
    localparam logic [4:0] OP_ORI  = 5'b11000;
    localparam logic [4:0] OP_XORI = 5'b11001;
    localparam logic [4:0] OP_SLL  = 5'b11010;
    localparam logic [4:0] OP_SRL  = 5'b11011;
    localparam logic [4:0] OP_SLT  = 5'b11100;
    localparam logic [4:0] OP_SLTI = 5'b11101;

    localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_br;
    logic                 a_lt_b;
    logic                 a_nz;
    logic                 accept_mult;

    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mplier_shift;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH:0]       hi_sum;
    logic [2*WIDTH:0]     sum;
    logic                 sign;
    logic                 mul_finish;
    logic [MUL_CNT_W-1:0] cnt;

    assign accept_mult = ValidIn && (ALUControl == OP_MULT);
    assign a_lt_b      = $signed(A) < $signed(B);
    assign a_nz        = (A != '0);

    // Single-cycle ALU result and branch condition
    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        case (ALUControl)
            OP_ADD, OP_ADDI, OP_SB, OP_LH, OP_LB, OP_SH: alu_res = A + B;
            OP_SUB:           alu_res = A - B;
            OP_AND, OP_ANDI:  alu_res = A & B;
            OP_OR, OP_ORI:    alu_res = A | B;
            OP_NOR:           alu_res = ~(A | B);
            OP_XOR, OP_XORI:  alu_res = A ^ B;
            OP_SLL:           alu_res = B << Shamt;
            OP_SRL:           alu_res = B >> Shamt;
            OP_SLT, OP_SLTI:  alu_res = {{(WIDTH-1){1'b0}}, a_lt_b};
            OP_JR:            alu_res = A;
            OP_BGEZ:          alu_br  = ~A[WIDTH-1];
            OP_BEQ:           alu_br  = (A == B);
            OP_BNE:           alu_br  = (A != B);
            OP_BGTZ:          alu_br  = ~A[WIDTH-1] & a_nz;
            OP_BLEZ:          alu_br  = A[WIDTH-1] | ~a_nz;
            OP_BLTZ:          alu_br  = A[WIDTH-1];
            default:          ;
        endcase
    end

    // One shift-add multiplier iteration (with optional early finish)
    always_comb begin
        hi_sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        sum          = {hi_sum, acc[WIDTH-1:0]};
        mplier_shift = mplier >> 1;
`ifdef MULT_EARLY_EXIT_EN
        // Remaining iterations would only shift, so apply them all at once.
        if (mplier_shift == '0) begin
            acc_next   = (2*WIDTH)'(sum >> (MUL_CNT_W'(WIDTH) - cnt));
            mul_finish = 1'b1;
        end else begin
            acc_next   = (2*WIDTH)'(sum >> 1);
            mul_finish = (cnt == CNT_LAST);
        end
`else
        acc_next   = (2*WIDTH)'(sum >> 1);
        mul_finish = (cnt == CNT_LAST);
`endif
        prod = sign ? (~acc + 1'b1) : acc;
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // FSM next state and combinational stall
    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_mult) begin
                    state_next = S_MUL;
                    Stall      = 1'b1;
                end
            end
            S_MUL: begin
                Stall = 1'b1;
                if (mul_finish) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Registered results, HI/LO and multiplier datapath
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ALUResult <= '0;
            Branch    <= 1'b0;
            ValidOut  <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            sign      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_mult) begin
                        mcand    <= A[WIDTH-1] ? (~A + 1'b1) : A;
                        mplier   <= B[WIDTH-1] ? (~B + 1'b1) : B;
                        sign     <= A[WIDTH-1] ^ B[WIDTH-1];
                        acc      <= '0;
                        cnt      <= '0;
                        ValidOut <= 1'b0;
                    end else if (ValidIn) begin
                        ALUResult <= alu_res;
                        Branch    <= alu_br;
                        ValidOut  <= 1'b1;
                    end else begin
                        ValidOut <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc      <= acc_next;
                    mplier   <= mplier_shift;
                    cnt      <= cnt + MUL_CNT_W'(1);
                    ValidOut <= 1'b0;
                end
                S_DONE: begin
                    Hi        <= prod[2*WIDTH-1:WIDTH];
                    Lo        <= prod[WIDTH-1:0];
                    ALUResult <= prod[WIDTH-1:0];
                    Branch    <= 1'b0;
                    ValidOut  <= 1'b1;
                end
                default: ValidOut <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_alu_mult_unit.sv
// Randomised self-checking bench for ex_alu_mult_unit against a
// behavioural model (integer arithmetic and a 64-bit signed multiply).
module tb_ex_alu_mult_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        ValidIn;
    logic [4:0]  ALUControl;
    logic [31:0] A, B;
    logic [4:0]  Shamt;
    logic [31:0] ALUResult;
    logic        Branch;
    logic        ValidOut;
    logic [31:0] Hi, Lo;
    logic        Stall;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_res = '0;
    logic        exp_br  = 1'b0;
    logic [31:0] exp_hi  = '0;
    logic [31:0] exp_lo  = '0;

    ex_alu_mult_unit #(.WIDTH(32), .MUL_CNT_W(6)) dut (
        .Clk(Clk), .Rst(Rst), .ValidIn(ValidIn), .ALUControl(ALUControl),
        .A(A), .B(B), .Shamt(Shamt), .ALUResult(ALUResult), .Branch(Branch),
        .ValidOut(ValidOut), .Hi(Hi), .Lo(Lo), .Stall(Stall)
    );

    always #5 Clk = ~Clk;

    // Hard bound on the whole run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural model of one single-cycle operation
    task automatic model_alu(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] sh, output logic [31:0] r, output logic br);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        r  = 32'd0;
        br = 1'b0;
        case (code)
            5'd0, 5'd1, 5'd6, 5'd7, 5'd8, 5'd9: r = a + b;
            5'd2:          r = a - b;
            5'd19, 5'd20:  r = a & b;
            5'd21, 5'd24:  r = a | b;
            5'd22:         r = ~(a | b);
            5'd23, 5'd25:  r = a ^ b;
            5'd26:         r = a * 0 + (b << sh);
            5'd27:         r = b >> sh;
            5'd28, 5'd29:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd17:         r = a;
            5'd10:         br = (sa >= 0);
            5'd11:         br = (a == b);
            5'd12:         br = (a != b);
            5'd13:         br = (sa > 0);
            5'd14:         br = (sa <= 0);
            5'd15:         br = (sa < 0);
            default:       ;
        endcase
    endtask

    task automatic do_op(input logic v, input logic [4:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input string tag);
        logic [31:0] r;
        logic        br;
        ValidIn = v; ALUControl = code; A = a; B = b; Shamt = sh;
        #1;
        check({tag, "_stall"}, Stall, 0);
        @(posedge Clk); #1;
        if (v) begin
            model_alu(code, a, b, sh, r, br);
            exp_res = r;
            exp_br  = br;
        end
        check({tag, "_res"},   ALUResult, exp_res);
        check({tag, "_br"},    Branch, exp_br);
        check({tag, "_valid"}, ValidOut, v);
        check({tag, "_hi"},    Hi, exp_hi);
        check({tag, "_lo"},    Lo, exp_lo);
    endtask

    function automatic int msb_index(input logic [31:0] x);
        int idx = 0;
        for (int i = 0; i < 32; i++) if (x[i]) idx = i;
        return idx;
    endfunction

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit chain,
                           input string tag);
        longint      p;
        logic [63:0] pv;
        logic [31:0] mag;
        int          stall_n, exp_stall;
        ValidIn = 1'b1; ALUControl = 5'd3; A = a; B = b; Shamt = '0;
        #1;
        check({tag, "_stall_accept"}, Stall, 1);
        stall_n = 1;
        @(posedge Clk); #1;
        if (chain) begin
            ALUControl = 5'd0; A = 32'd1; B = 32'd2; ValidIn = 1'b1;
        end else begin
            ValidIn = 1'b0;
        end
        while (Stall === 1'b1 && stall_n < 200) begin
            stall_n++;
            @(posedge Clk); #1;
        end
        mag = b[31] ? (~b + 1) : b;
`ifdef MULT_EARLY_EXIT_EN
        exp_stall = (mag == 0) ? 2 : 2 + msb_index(mag);
`else
        exp_stall = 33 + 0 * msb_index(mag);
`endif
        check({tag, "_stall_len"}, stall_n, exp_stall);
        check({tag, "_valid_done"}, ValidOut, 0);
        @(posedge Clk); #1;
        p  = longint'(int'(a)) * longint'(int'(b));
        pv = p;
        exp_hi  = pv[63:32];
        exp_lo  = pv[31:0];
        exp_res = pv[31:0];
        exp_br  = 1'b0;
        check({tag, "_valid"}, ValidOut, 1);
        check({tag, "_hi"},    Hi, exp_hi);
        check({tag, "_lo"},    Lo, exp_lo);
        check({tag, "_res"},   ALUResult, exp_res);
        check({tag, "_br"},    Branch, 0);
        @(posedge Clk); #1;
        if (chain) begin
            exp_res = 32'd3;
            check({tag, "_add_valid"}, ValidOut, 1);
            check({tag, "_add_res"},   ALUResult, 32'd3);
        end else begin
            check({tag, "_pulse"}, ValidOut, 0);
            check({tag, "_hold"},  ALUResult, exp_res);
        end
        check({tag, "_hi_keep"}, Hi, exp_hi);
        check({tag, "_lo_keep"}, Lo, exp_lo);
        ValidIn = 1'b0;
    endtask

    initial begin
        logic [4:0]  code;
        logic [31:0] ra, rb;
        logic        rv;

        Rst = 1'b0; ValidIn = 1'b0; ALUControl = '0; A = '0; B = '0; Shamt = '0;
        #1;
        check("rst_res", ALUResult, 0);
        check("rst_br", Branch, 0);
        check("rst_valid", ValidOut, 0);
        check("rst_hi", Hi, 0);
        check("rst_lo", Lo, 0);
        check("rst_stall", Stall, 0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;

        // Logic/arithmetic sweep over every listed R/I code
        for (int c = 0; c < 32; c++) begin
            if (c != 3) do_op(1'b1, 5'(c), 32'hFFFF0000, 32'h0F0F0F0F, 5'd4, "sweep");
        end
        do_op(1'b1, 5'b10011, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, "and");
        check("and_const", ALUResult, 32'h0F0F0000);
        do_op(1'b1, 5'b10101, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, "or");
        check("or_const", ALUResult, 32'hFFFF0F0F);
        do_op(1'b1, 5'b10110, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, "nor");
        check("nor_const", ALUResult, 32'h0000F0F0);
        do_op(1'b1, 5'b10111, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, "xor");
        check("xor_const", ALUResult, 32'hF0F00F0F);
        do_op(1'b1, 5'b11100, 32'hFFFFFFFF, 32'd1, 5'd0, "slt");
        check("slt_const", ALUResult, 32'd1);
        do_op(1'b1, 5'b11011, 32'd0, 32'h80000000, 5'd31, "srl");
        check("srl_const", ALUResult, 32'd1);

        // Branch conditions at negative and zero operands
        for (int c = 10; c < 16; c++) do_op(1'b1, 5'(c), 32'hFFFFFFFD, 32'hFFFFFFFD, 5'd0, "br_m3");
        for (int c = 10; c < 16; c++) do_op(1'b1, 5'(c), 32'd0, 32'd5, 5'd0, "br_zero");
        do_op(1'b1, 5'b01011, 32'hFFFFFFFD, 32'hFFFFFFFD, 5'd0, "beq");
        check("beq_const", Branch, 1);
        do_op(1'b1, 5'b01101, 32'd0, 32'd0, 5'd0, "bgtz0");
        check("bgtz0_const", Branch, 0);

        // Directed multiplies
        do_mult(32'hFFFFFFF9, 32'd6, 1'b0, "mul_m7x6");
        check("mul_m7x6_hi_const", Hi, 32'hFFFFFFFF);
        check("mul_m7x6_lo_const", Lo, 32'hFFFFFFD6);
        do_mult(32'h80000000, 32'h80000000, 1'b0, "mul_min");
        check("mul_min_hi_const", Hi, 32'h40000000);
        check("mul_min_lo_const", Lo, 32'h0);
        do_mult(32'h12345678, 32'd6, 1'b0, "mul_pre");
        do_mult(32'h12345678, 32'd0, 1'b0, "mul_zero");
        do_mult(32'hFFFFFFF9, 32'd6, 1'b1, "mul_chain");

        // Reset in the middle of a multiply
        ValidIn = 1'b1; ALUControl = 5'd3; A = 32'h00001234; B = 32'h7FFFFFFF;
        @(posedge Clk); #1;
        ValidIn = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        check("rstmul_busy", Stall, 1);
        Rst = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0; exp_res = '0; exp_br = 1'b0;
        check("rstmul_stall", Stall, 0);
        check("rstmul_hi", Hi, 0);
        check("rstmul_lo", Lo, 0);
        check("rstmul_valid", ValidOut, 0);
        @(negedge Clk);
        Rst = 1'b1;
        do_op(1'b1, 5'd0, 32'd5, 32'd7, 5'd0, "post_rst_add");
        check("post_rst_add_const", ALUResult, 32'd12);

        // Random single-cycle traffic, including idle cycles and unlisted codes
        for (int i = 0; i < 300; i++) begin
            code = 5'($urandom_range(0, 31));
            if (code == 5'd3) code = 5'd0;
            rv = ($urandom_range(0, 7) != 0);
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? ra : $urandom;
            if ($urandom_range(0, 9) == 0) ra = '0;
            do_op(rv, code, ra, rb, 5'($urandom), "rand");
        end

        // Random multiplies with varied multiplier magnitude
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 3 == 0) rb = ~rb + 1;
            do_mult(ra, rb, (i % 2) == 1, "rmul");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
